// File: rtl/demux_tdm_4.sv
// demux_tdm_4: TDM receive demux. A rotating slot counter steers serial samples into an N-lane frame.
// Build option: define DEMUX_SYNC_EN to add the FrameSync port, which realigns the slot counter mid-stream.
`timescale 1ns/1ps
module demux_tdm_4 #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int SW = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [W-1:0]   In,
    input  logic           InValid,
    output logic           InReady,
    output logic [SW-1:0]  Sel,
    output logic [N*W-1:0] Out,
    output logic           OutValid,
    input  logic           OutReady
`ifdef DEMUX_SYNC_EN
    ,
    input  logic           FrameSync
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t     out_state;
    logic [N*W-1:0] shadow;
    logic [N*W-1:0] frame;
    logic           last_slot;
    logic           stall;
    logic           accept;
    logic           sync_accept;
    logic           complete;

    assign last_slot = (Sel == SW'(N - 1));
    // The last slot can only be taken when the output register can make room for the frame.
    assign stall     = last_slot && OutValid && !OutReady;

`ifdef DEMUX_SYNC_EN
    assign InReady     = !stall || (InValid && FrameSync);
    assign sync_accept = accept && FrameSync;
`else
    assign InReady     = !stall;
    assign sync_accept = 1'b0;
`endif

    assign accept   = InValid && InReady;
    assign complete = accept && !sync_accept && last_slot;

    always_comb begin
        frame = shadow;
        frame[(N-1)*W +: W] = In;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Sel       <= '0;
            shadow    <= '0;
            Out       <= '0;
            OutValid  <= 1'b0;
            out_state <= EMPTY;
        end else begin
            if (accept) begin
                if (sync_accept) begin
                    shadow[0 +: W] <= In;
                    Sel            <= SW'(1);
                end else begin
                    shadow[Sel*W +: W] <= In;
                    Sel                <= last_slot ? '0 : Sel + SW'(1);
                end
            end

            case (out_state)
                EMPTY: begin
                    if (complete) begin
                        Out       <= frame;
                        OutValid  <= 1'b1;
                        out_state <= FULL;
                    end
                end
                FULL: begin
                    if (complete) begin
                        Out <= frame;
                    end else if (OutReady) begin
                        OutValid  <= 1'b0;
                        out_state <= EMPTY;
                    end
                end
                default: begin
                    OutValid  <= 1'b0;
                    out_state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_tdm_4.sv
// Self-checking bench for demux_tdm_4: table vectors plus hand sequences, frames checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_demux_tdm_4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [0:0] In;
    logic       InValid;
    logic       InReady;
    logic [1:0] Sel;
    logic [3:0] Out;
    logic       OutValid;
    logic       OutReady;
    logic       FrameSync;

    int         checks = 0;
    int         errors = 0;
    int         cnt;
    logic [3:0] acc;
    logic [3:0] last_out;
    logic [3:0] sb[$];

    typedef struct {
        logic in_bit;
        logic in_valid;
        logic out_ready;
        logic exp_ready;
        logic exp_valid;
    } vec_t;

    vec_t vecs [18];

    demux_tdm_4 #(
        .N (4),
        .W (1),
        .SW(2)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .In       (In),
        .InValid  (InValid),
        .InReady  (InReady),
        .Sel      (Sel),
        .Out      (Out),
        .OutValid (OutValid),
        .OutReady (OutReady)
`ifdef DEMUX_SYNC_EN
        ,
        .FrameSync(FrameSync)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check the pre-edge state, then advance the model over the coming edge.
    task automatic cycle(input logic i, input logic v, input logic r, input logic f,
                         input bit use_tbl, input logic t_ready, input logic t_valid);
        logic       exp_ready;
        logic       exp_valid;
        logic       sync;
        logic [3:0] exp_out;
        @(negedge Clk);
        In        = i;
        InValid   = v;
        OutReady  = r;
        FrameSync = f;
        #1;
        exp_valid = (sb.size() != 0);
        exp_ready = !(cnt == 3 && exp_valid && !r);
`ifdef DEMUX_SYNC_EN
        exp_ready = exp_ready || (v && f);
        sync      = v && f;
`else
        sync      = 1'b0;
`endif
        exp_out = exp_valid ? sb[0] : last_out;
        chk("sel", Sel, cnt);
        chk("in_ready", InReady, exp_ready);
        chk("out_valid", OutValid, exp_valid);
        chk("out", Out, exp_out);
        if (use_tbl) begin
            chk("tbl_in_ready", InReady, t_ready);
            chk("tbl_out_valid", OutValid, t_valid);
        end
        if (exp_valid && r)
            last_out = sb.pop_front();
        if (v && exp_ready) begin
            if (sync) begin
                acc[0] = i;
                cnt    = 1;
            end else begin
                acc[cnt] = i;
                if (cnt == 3)
                    sb.push_back(acc);
                cnt = (cnt + 1) % 4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset     = 1'b1;
        InValid   = 1'b0;
        OutReady  = 1'b0;
        FrameSync = 1'b0;
        In        = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("reset_sel", Sel, 0);
        chk("reset_out_valid", OutValid, 0);
        chk("reset_out", Out, 0);
        cnt      = 0;
        acc      = '0;
        last_out = '0;
        sb.delete();
    endtask

    initial begin
        vecs = '{
            '{1, 1, 1, 1, 0}, '{0, 1, 1, 1, 0}, '{1, 1, 1, 1, 0}, '{1, 1, 1, 1, 0},
            '{0, 0, 1, 1, 1}, '{0, 0, 1, 1, 0},
            '{0, 1, 0, 1, 0}, '{1, 1, 0, 1, 0}, '{0, 1, 0, 1, 0}, '{1, 1, 0, 1, 0},
            '{1, 1, 0, 1, 1}, '{0, 1, 0, 1, 1}, '{1, 1, 0, 1, 1}, '{0, 1, 0, 0, 1},
            '{0, 1, 0, 0, 1}, '{0, 1, 1, 1, 1}, '{0, 0, 1, 1, 1}, '{0, 0, 1, 1, 0}
        };
        Reset     = 1'b1;
        In        = 1'b0;
        InValid   = 1'b0;
        OutReady  = 1'b0;
        FrameSync = 1'b0;
        cnt       = 0;
        acc       = '0;
        last_out  = '0;
        do_reset();

        // Single frame 1101, then back-to-back frames A and 5 against a stalled consumer.
        for (int k = 0; k < 18; k++) begin
            cycle(vecs[k].in_bit, vecs[k].in_valid, vecs[k].out_ready, 1'b0,
                  1'b1, vecs[k].exp_ready, vecs[k].exp_valid);
            if (k == 4)
                chk("frame_1101", Out, 4'b1101);
        end

        // Reset mid-frame discards the partial frame; next four samples form 0110.
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        do_reset();
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("frame_after_reset", Out, 4'b0110);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // InValid toggling; idle cycles carry junk on In.
        begin
            logic [3:0] bits;
            bits = 4'b1011;
            for (int k = 0; k < 8; k++) begin
                if (k % 2 == 0)
                    cycle(bits[k/2], 1, 1, 0, 0, 0, 0);
                else
                    cycle(~bits[k/2], 0, 1, 0, 0, 0, 0);
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("frame_toggle", Out, 4'b1011);
        cycle(0, 0, 1, 0, 0, 0, 0);

`ifdef DEMUX_SYNC_EN
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 0);
        chk("sync_sel_pre", Sel, 2);
        cycle(0, 0, 1, 1, 0, 0, 0);
        chk("sync_sel", Sel, 1);
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("sync_frame", Out, 4'b0101);
        cycle(0, 0, 1, 0, 0, 0, 0);
`endif

        for (int k = 0; k < 120; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0), 0, 0, 0);
        end
        for (int k = 0; k < 3; k++)
            cycle(0, 0, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
